// File: rtl/fpu_issue_ctrl_pkg.sv
// fpu_issue_ctrl_pkg: shared widths, default lane count and fflag bit positions
package fpu_issue_ctrl_pkg;
    localparam int DEF_NUM_THREADS = 4;
    localparam int INST_FPU_BITS   = 4;
    localparam int INST_MOD_BITS   = 3;
    localparam int RD_BITS         = 5;
    localparam int PC_BITS         = 32;
    localparam int FFLAGS_BITS     = 5;
    localparam int FFLAG_NV        = 4;
    localparam int FFLAG_DZ        = 3;
    localparam int FFLAG_OF        = 2;
    localparam int FFLAG_UF        = 1;
    localparam int FFLAG_NX        = 0;
endpackage

// File: rtl/fpu_tag_alloc.sv
// fpu_tag_alloc: busy mask with lowest-free tag allocation; allocation sees only the pre-edge mask
module fpu_tag_alloc #(
    parameter int TAGW = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   set_en,
    input  logic                   clr_en,
    input  logic [TAGW-1:0]        clr_tag,
    output logic [TAGW-1:0]        alloc_tag,
    output logic                   full,
    output logic [(1<<TAGW)-1:0]   busy_mask
);
    localparam int NTAGS = 1 << TAGW;

    logic [NTAGS-1:0] busy_q, busy_d;

    always_comb begin
        alloc_tag = '0;
        for (int i = NTAGS - 1; i >= 0; i--)
            if (!busy_q[i]) alloc_tag = TAGW'(i);
        busy_d = busy_q;
        if (set_en) busy_d[alloc_tag] = 1'b1;
        if (clr_en) busy_d[clr_tag] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) busy_q <= '0;
        else       busy_q <= busy_d;

    assign full      = &busy_q;
    assign busy_mask = busy_q;
endmodule

// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: tags FP requests toward the FPU, keeps per-tag metadata and
// registers FPU responses for writeback with lane-reduced fflags.
module fpu_issue_ctrl
    import fpu_issue_ctrl_pkg::*;
#(
    parameter int TAGW        = 2,
    parameter int NUM_THREADS = DEF_NUM_THREADS,
    parameter int NW_BITS     = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [NW_BITS-1:0]          req_wid,
    input  logic [RD_BITS-1:0]          req_rd,
    input  logic                        req_wb,
    input  logic [PC_BITS-1:0]          req_pc,
    input  logic [NUM_THREADS-1:0]      req_tmask,
    input  logic [INST_FPU_BITS-1:0]    req_op_type,
    input  logic [INST_MOD_BITS-1:0]    req_frm,
    input  logic [NUM_THREADS*32-1:0]   req_dataa,
    input  logic [NUM_THREADS*32-1:0]   req_datab,
    input  logic [NUM_THREADS*32-1:0]   req_datac,
    output logic                        fpu_valid_in,
    input  logic                        fpu_ready_in,
    output logic [TAGW-1:0]             fpu_tag_in,
    output logic [INST_FPU_BITS-1:0]    fpu_op_type,
    output logic [INST_MOD_BITS-1:0]    fpu_frm,
    output logic [NUM_THREADS*32-1:0]   fpu_dataa,
    output logic [NUM_THREADS*32-1:0]   fpu_datab,
    output logic [NUM_THREADS*32-1:0]   fpu_datac,
    input  logic                        fpu_valid_out,
    output logic                        fpu_ready_out,
    input  logic [TAGW-1:0]             fpu_tag_out,
    input  logic [NUM_THREADS*32-1:0]   fpu_result,
    input  logic                        fpu_has_fflags,
    input  logic [NUM_THREADS-1:0]      fpu_fflags_NV,
    input  logic [NUM_THREADS-1:0]      fpu_fflags_DZ,
    input  logic [NUM_THREADS-1:0]      fpu_fflags_OF,
    input  logic [NUM_THREADS-1:0]      fpu_fflags_UF,
    input  logic [NUM_THREADS-1:0]      fpu_fflags_NX,
    output logic                        commit_valid,
    input  logic                        commit_ready,
    output logic [NW_BITS-1:0]          commit_wid,
    output logic [RD_BITS-1:0]          commit_rd,
    output logic                        commit_wb,
    output logic [PC_BITS-1:0]          commit_pc,
    output logic [NUM_THREADS-1:0]      commit_tmask,
    output logic [NUM_THREADS*32-1:0]   commit_data,
    output logic                        fflags_valid,
    output logic [NW_BITS-1:0]          fflags_wid,
    output logic [FFLAGS_BITS-1:0]      fflags,
    output logic                        busy
);
    localparam int NTAGS = 1 << TAGW;

    typedef struct packed {
        logic [NW_BITS-1:0]     wid;
        logic [RD_BITS-1:0]     rd;
        logic                   wb;
        logic [PC_BITS-1:0]     pc;
        logic [NUM_THREADS-1:0] tmask;
    } meta_t;

    meta_t                      meta_q [NTAGS];
    meta_t                      meta_d, rsp_meta, commit_q, commit_d;
    logic                       full, issue, resp_acc;
    logic [TAGW-1:0]            alloc_tag;
    logic [NTAGS-1:0]           busy_mask;
    logic                       commit_valid_q, commit_valid_d;
    logic                       has_fflags_q, has_fflags_d;
    logic [FFLAGS_BITS-1:0]     fflags_q, fflags_d, rsp_fflags;
    logic [NUM_THREADS*32-1:0]  data_q, data_d;

    fpu_tag_alloc #(.TAGW(TAGW)) u_alloc (
        .clk       (clk),
        .reset     (reset),
        .set_en    (issue),
        .clr_en    (resp_acc),
        .clr_tag   (fpu_tag_out),
        .alloc_tag (alloc_tag),
        .full      (full),
        .busy_mask (busy_mask)
    );

    assign fpu_valid_in  = req_valid && !full;
    assign req_ready     = fpu_ready_in && !full;
    assign issue         = req_valid && req_ready;
    assign fpu_tag_in    = alloc_tag;
    assign fpu_op_type   = req_op_type;
    assign fpu_frm       = req_frm;
    assign fpu_dataa     = req_dataa;
    assign fpu_datab     = req_datab;
    assign fpu_datac     = req_datac;
    assign fpu_ready_out = !commit_valid_q || commit_ready;
    assign resp_acc      = fpu_valid_out && fpu_ready_out;

    always_comb begin
        meta_d                 = {req_wid, req_rd, req_wb, req_pc, req_tmask};
        rsp_meta               = meta_q[fpu_tag_out];
        // flags from lanes outside the issued thread mask are ignored
        rsp_fflags             = '0;
        rsp_fflags[FFLAG_NV]   = |(fpu_fflags_NV & rsp_meta.tmask);
        rsp_fflags[FFLAG_DZ]   = |(fpu_fflags_DZ & rsp_meta.tmask);
        rsp_fflags[FFLAG_OF]   = |(fpu_fflags_OF & rsp_meta.tmask);
        rsp_fflags[FFLAG_UF]   = |(fpu_fflags_UF & rsp_meta.tmask);
        rsp_fflags[FFLAG_NX]   = |(fpu_fflags_NX & rsp_meta.tmask);
        commit_d               = resp_acc ? rsp_meta : commit_q;
        data_d                 = resp_acc ? fpu_result : data_q;
        fflags_d               = resp_acc ? rsp_fflags : fflags_q;
        has_fflags_d           = resp_acc ? fpu_has_fflags : has_fflags_q;
        commit_valid_d         = resp_acc || (commit_valid_q && !commit_ready);
    end

    always_ff @(posedge clk)
        if (issue) meta_q[alloc_tag] <= meta_d;

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            commit_valid_q <= 1'b0;
            commit_q       <= '0;
            data_q         <= '0;
            fflags_q       <= '0;
            has_fflags_q   <= 1'b0;
        end else begin
            commit_valid_q <= commit_valid_d;
            commit_q       <= commit_d;
            data_q         <= data_d;
            fflags_q       <= fflags_d;
            has_fflags_q   <= has_fflags_d;
        end

    assign commit_valid = commit_valid_q;
    assign commit_wid   = commit_q.wid;
    assign commit_rd    = commit_q.rd;
    assign commit_wb    = commit_q.wb;
    assign commit_pc    = commit_q.pc;
    assign commit_tmask = commit_q.tmask;
    assign commit_data  = data_q;
    assign fflags_valid = commit_valid_q && commit_ready && has_fflags_q;
    assign fflags_wid   = commit_q.wid;
    assign fflags       = fflags_q;
    assign busy         = |busy_mask;

    a_resp_tag_busy: assert property (@(posedge clk) disable iff (reset) resp_acc |-> busy_mask[fpu_tag_out]);
endmodule
